// File: rtl/demux_pkg.sv
// Shared constants and slot state type for the 1-to-4 stream demultiplexer.
package demux_pkg;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel, with an optional
// saturating accepted-beat counter built only when DEMUX_1X4_CNT_EN is defined.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rdReady,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_cnt
);

    slot_state_t      r_state;
    logic [WIDTH-1:0] r_data;

    // A write always wins: when the consumer drains in the same cycle it has
    // already taken the old data, so the slot simply stays FULL with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else if (i_wr) begin
            r_state <= FULL;
            r_data  <= i_wdata;
        end else if (i_rdReady) begin
            r_state <= EMPTY;
        end
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;

`ifdef DEMUX_1X4_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_wr && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
`else
    assign o_cnt = '0;
`endif

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer; per-channel counters
// are enabled by defining DEMUX_1X4_CNT_EN.
module demux_1x4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_CH*WIDTH-1:0] out,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*CNT_W-1:0] cnt
);

    logic [N_CH-1:0] w_valid;
    logic [N_CH-1:0] w_wr;
    logic            w_accept;

    // The selected slot can take a beat if it is empty or draining this cycle.
    assign in_ready = !w_valid[sel] || out_ready[sel];
    assign w_accept = in_valid && in_ready;

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        assign w_wr[k] = w_accept && (sel == SEL_W'(k));

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_wr      (w_wr[k]),
            .i_wdata   (in),
            .i_rdReady (out_ready[k]),
            .o_valid   (w_valid[k]),
            .o_data    (out[k*WIDTH +: WIDTH]),
            .o_cnt     (cnt[k*CNT_W +: CNT_W])
        );
    end

    assign out_valid = w_valid;

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream: directed steps plus random traffic
// against a per-channel one-deep buffer model with delivery-order queues.
module tb_demux_1x4_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inData;
    logic [1:0]  sel;
    logic        inValid;
    logic        inReady;
    logic [31:0] outData;
    logic [3:0]  outValid;
    logic [3:0]  outReady;
    logic [63:0] cnt;

    int checks = 0;
    int errors = 0;
    int accepted = 0;

    bit        mValid [4];
    logic [7:0] mData [4];
    int        mCnt   [4];
    logic [7:0] sentQ [4][$];

    demux_1x4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (inData),
        .sel       (sel),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out       (outData),
        .out_valid (outValid),
        .out_ready (outReady),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 4; k++) begin
            mValid[k] = 1'b0;
            mData[k]  = 8'h00;
            mCnt[k]   = 0;
            sentQ[k].delete();
        end
    endtask

    function automatic logic [63:0] expectedCnt();
        logic [63:0] v;
        v = '0;
`ifdef DEMUX_1X4_CNT_EN
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = 16'(mCnt[k]);
`endif
        return v;
    endfunction

    // One clock cycle: drive, check combinational/registered outputs, clock, update model.
    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s, input logic v, input logic [3:0] rdy);
        logic expReady;
        logic [7:0] exp;
        inData   = d;
        sel      = s;
        inValid  = v;
        outReady = rdy;
        #1;
        expReady = !mValid[s] || rdy[s];
        checkOutput("inReady", {63'd0, inReady}, {63'd0, expReady});
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("outValid%0d", k), {63'd0, outValid[k]}, {63'd0, mValid[k]});
            checkOutput($sformatf("outData%0d", k), {56'd0, outData[k*8 +: 8]}, {56'd0, mData[k]});
            if (outValid[k] && rdy[k]) begin
                checkOutput($sformatf("deliverPending%0d", k), {63'd0, sentQ[k].size() > 0}, 64'd1);
                if (sentQ[k].size() > 0) begin
                    exp = sentQ[k].pop_front();
                    checkOutput($sformatf("deliverOrder%0d", k), {56'd0, outData[k*8 +: 8]}, {56'd0, exp});
                end
            end
        end
        checkOutput("cnt", cnt, expectedCnt());
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (mValid[k] && rdy[k]) mValid[k] = 1'b0;
        end
        if (v && expReady) begin
            accepted++;
            mValid[s] = 1'b1;
            mData[s]  = d;
            sentQ[s].push_back(d);
            if (mCnt[s] < 65535) mCnt[s]++;
        end
        @(negedge clk);
    endtask

    // Reset with a beat offered; nothing may be accepted and everything clears.
    task automatic doReset();
        rst      = 1'b1;
        inData   = 8'h5A;
        sel      = 2'd1;
        inValid  = 1'b1;
        outReady = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rstOutValid", {60'd0, outValid}, 64'd0);
        checkOutput("rstOut", {32'd0, outData}, 64'd0);
        checkOutput("rstCnt", cnt, 64'd0);
        checkOutput("rstInReady", {63'd0, inReady}, 64'd1);
        rst = 1'b0;
        clearModel();
    endtask

    initial begin
        int startAcc;
        rst      = 1'b1;
        inData   = '0;
        sel      = '0;
        inValid  = 1'b0;
        outReady = '0;
        clearModel();
        @(negedge clk);
        doReset();

        // Fill two slots, then reset mid-operation.
        applyStimulus(8'h33, 2'd0, 1'b1, 4'b0000);
        applyStimulus(8'h44, 2'd2, 1'b1, 4'b0000);
        doReset();

        // A5 to channel 2 with no consumers, then a blocked and an accepted beat.
        applyStimulus(8'hA5, 2'd2, 1'b1, 4'b0000);
        checkOutput("ch2ValidA5", {60'd0, outValid}, 64'h4);
        checkOutput("ch2DataA5", {56'd0, outData[23:16]}, 64'hA5);
        applyStimulus(8'hB6, 2'd2, 1'b1, 4'b0000);
        applyStimulus(8'hC7, 2'd1, 1'b1, 4'b0000);
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b1111);

        // Same-cycle drain and write on channel 3.
        applyStimulus(8'h11, 2'd3, 1'b1, 4'b0000);
        applyStimulus(8'h22, 2'd3, 1'b1, 4'b1000);
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b0000);
        checkOutput("ch3Holds22", {56'd0, outData[31:24]}, 64'h22);
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b1111);

        // Full-rate round-robin stream.
        startAcc = accepted;
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 2'(i % 4), 1'b1, 4'b1111);
        checkOutput("streamBeats", 64'(accepted - startAcc), 64'd16);
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b1111);

        // Stalled channel 0 must not block other channels.
        applyStimulus(8'h77, 2'd0, 1'b1, 4'b0000);
        startAcc = accepted;
        for (int i = 0; i < 10; i++) applyStimulus(8'(8'h80 + i), 2'(1 + i % 3), 1'b1, 4'b1110);
        checkOutput("bypassBeats", 64'(accepted - startAcc), 64'd10);
        checkOutput("ch0Held", {56'd0, outData[7:0]}, 64'h77);
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b1111);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(8'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
        end
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b1111);

`ifdef DEMUX_1X4_CNT_EN
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(8'(i), 2'd1, 1'b1, 4'b1111);
        checkOutput("cnt1Five", {48'd0, cnt[31:16]}, 64'd5);
        checkOutput("cntOthersZero", {16'd0, cnt[63:32], cnt[15:0]}, 64'd0);
        for (int i = 0; i < 70000; i++) applyStimulus(8'(i), 2'd0, 1'b1, 4'b1111);
        checkOutput("cnt0Saturated", {48'd0, cnt[15:0]}, 64'hFFFF);
`else
        checkOutput("cntTiedZero", cnt, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
